// File: rtl/dphy_tx_packetizer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dphy_tx_packetizer_if : request / payload / HS-driver bundle for the packetizer
// Rev 1.0
// ----------------------------------------------------------------------------
interface dphy_tx_packetizer_if #(
  parameter int WC_W = 16
);
  logic            pkt_start;
  logic            pkt_long;
  logic [7:0]      pkt_di;
  logic [WC_W-1:0] pkt_wc;
  logic [7:0]      app_data;
  logic            app_valid;
  logic            app_ready;
  logic            TX_REQ;
  logic            TX_VALID;
  logic [7:0]      TX_BYTE_HS;
  logic            TX_READY;
  logic            busy;
  logic            pkt_done;

  modport master (
    input  pkt_start, pkt_long, pkt_di, pkt_wc, app_data, app_valid, TX_READY,
    output app_ready, TX_REQ, TX_VALID, TX_BYTE_HS, busy, pkt_done
  );

  modport slave (
    output pkt_start, pkt_long, pkt_di, pkt_wc, app_data, app_valid, TX_READY,
    input  app_ready, TX_REQ, TX_VALID, TX_BYTE_HS, busy, pkt_done
  );
endinterface
`default_nettype wire

// File: rtl/dphy_tx_packetizer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dphy_tx_packetizer : CSI-2 header+ECC / payload / CRC-16 byte feeder for the HS driver
// Rev 1.0
// ----------------------------------------------------------------------------
module dphy_tx_packetizer #(
  parameter int LP_GAP = 8,
  parameter int WC_W   = 16
) (
  input  logic                 TX_BYTE_clk,
  input  logic                 TX_rst,
  dphy_tx_packetizer_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PAY  = 3'd2;
  localparam logic [2:0] S_CRC  = 3'd3;
  localparam logic [2:0] S_END  = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  localparam logic [7:0]      GAP_LOAD = 8'(LP_GAP - 1);
  localparam logic [WC_W-1:0] WC_ONE   = WC_W'(1);

  // Header Hamming code: each parity bit is the XOR of the data bits in its mask
  function automatic logic [7:0] f_ecc(input logic [23:0] d);
    f_ecc = {2'b00, ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
             ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction

  function automatic logic [15:0] f_crc(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  logic [2:0]      r_state, w_state_nxt;
  logic [WC_W-1:0] r_wc, w_wc_nxt;
  logic [WC_W-1:0] r_rem, w_rem_nxt;
  logic            r_long, w_long_nxt;
  logic [7:0]      r_ecc, w_ecc_nxt;
  logic [1:0]      r_idx, w_idx_nxt;
  logic [15:0]     r_crc, w_crc_nxt;
  logic [7:0]      r_gap, w_gap_nxt;
  logic            r_tx_req, w_tx_req_nxt;
  logic            r_tx_valid, w_tx_valid_nxt;
  logic [7:0]      r_tx_byte, w_tx_byte_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_pkt_done, w_pkt_done_nxt;

  logic w_xfer, w_app_ready, w_app_acc, w_wc_zero;

  assign w_xfer      = r_tx_valid & bus.TX_READY;
  assign w_app_ready = (r_state == S_PAY) && (r_rem != '0) && (!r_tx_valid || bus.TX_READY);
  assign w_app_acc   = w_app_ready & bus.app_valid;
  assign w_wc_zero   = (r_wc == '0);

  always_ff @(posedge TX_BYTE_clk or posedge TX_rst) begin
    if (TX_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.pkt_start) w_state_nxt = S_HDR;
      S_HDR: begin
        if (w_xfer && (r_idx == 2'd3)) begin
          if (!r_long)       w_state_nxt = S_END;
          else if (w_wc_zero) w_state_nxt = S_CRC;
          else               w_state_nxt = S_PAY;
        end
      end
      S_PAY:   if (w_xfer && (r_rem == '0)) w_state_nxt = S_CRC;
      S_CRC:   if (w_xfer && (r_idx == 2'd1)) w_state_nxt = S_END;
      S_END:   w_state_nxt = S_GAP;
      S_GAP:   if (r_gap == 8'd0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_wc_nxt       = r_wc;
    w_rem_nxt      = r_rem;
    w_long_nxt     = r_long;
    w_ecc_nxt      = r_ecc;
    w_idx_nxt      = r_idx;
    w_crc_nxt      = r_crc;
    w_gap_nxt      = r_gap;
    w_tx_req_nxt   = r_tx_req;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_byte_nxt  = r_tx_byte;
    w_busy_nxt     = r_busy;
    w_pkt_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.pkt_start) begin
          w_wc_nxt       = bus.pkt_wc;
          w_rem_nxt      = bus.pkt_wc;
          w_long_nxt     = bus.pkt_long;
          w_ecc_nxt      = f_ecc({bus.pkt_wc, bus.pkt_di});
          w_idx_nxt      = 2'd0;
          w_crc_nxt      = 16'hFFFF;
          w_tx_req_nxt   = 1'b1;
          w_tx_valid_nxt = 1'b1;
          w_tx_byte_nxt  = bus.pkt_di;
          w_busy_nxt     = 1'b1;
        end
      end
      S_HDR: begin
        if (w_xfer) begin
          w_idx_nxt = r_idx + 2'd1;
          case (r_idx)
            2'd0: w_tx_byte_nxt = r_wc[7:0];
            2'd1: w_tx_byte_nxt = r_wc[15:8];
            2'd2: w_tx_byte_nxt = r_ecc;
            default: begin
              w_idx_nxt = 2'd0;
              if (!r_long) begin
                w_tx_valid_nxt = 1'b0;
                w_tx_req_nxt   = 1'b0;
                w_pkt_done_nxt = 1'b1;
              end else if (w_wc_zero) begin
                w_tx_byte_nxt = r_crc[7:0];
              end else begin
                w_tx_valid_nxt = 1'b0;
              end
            end
          endcase
        end
      end
      S_PAY: begin
        if (w_app_acc) begin
          w_tx_byte_nxt  = bus.app_data;
          w_tx_valid_nxt = 1'b1;
          w_rem_nxt      = r_rem - WC_ONE;
          w_crc_nxt      = f_crc(r_crc, bus.app_data);
        end else if (w_xfer) begin
          // The last payload byte has left, so the CRC already covers it
          if (r_rem == '0) begin
            w_tx_byte_nxt = r_crc[7:0];
            w_idx_nxt     = 2'd0;
          end else begin
            w_tx_valid_nxt = 1'b0;
          end
        end
      end
      S_CRC: begin
        if (w_xfer) begin
          if (r_idx == 2'd0) begin
            w_tx_byte_nxt = r_crc[15:8];
            w_idx_nxt     = 2'd1;
          end else begin
            w_tx_valid_nxt = 1'b0;
            w_tx_req_nxt   = 1'b0;
            w_pkt_done_nxt = 1'b1;
          end
        end
      end
      S_END: w_gap_nxt = GAP_LOAD;
      S_GAP: begin
        if (r_gap == 8'd0) w_busy_nxt = 1'b0;
        else               w_gap_nxt  = r_gap - 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge TX_BYTE_clk or posedge TX_rst) begin
    if (TX_rst) begin
      r_wc       <= '0;
      r_rem      <= '0;
      r_long     <= 1'b0;
      r_ecc      <= 8'h00;
      r_idx      <= 2'd0;
      r_crc      <= 16'h0000;
      r_gap      <= 8'd0;
      r_tx_req   <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_busy     <= 1'b0;
      r_pkt_done <= 1'b0;
    end else begin
      r_wc       <= w_wc_nxt;
      r_rem      <= w_rem_nxt;
      r_long     <= w_long_nxt;
      r_ecc      <= w_ecc_nxt;
      r_idx      <= w_idx_nxt;
      r_crc      <= w_crc_nxt;
      r_gap      <= w_gap_nxt;
      r_tx_req   <= w_tx_req_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_byte  <= w_tx_byte_nxt;
      r_busy     <= w_busy_nxt;
      r_pkt_done <= w_pkt_done_nxt;
    end
  end

  assign bus.app_ready  = w_app_ready;
  assign bus.TX_REQ     = r_tx_req;
  assign bus.TX_VALID   = r_tx_valid;
  assign bus.TX_BYTE_HS = r_tx_byte;
  assign bus.busy       = r_busy;
  assign bus.pkt_done   = r_pkt_done;

endmodule
`default_nettype wire

// File: tb/tb_dphy_tx_packetizer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dphy_tx_packetizer : directed self-checking bench for dphy_tx_packetizer
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dphy_tx_packetizer;

  localparam int GAP = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dphy_tx_packetizer_if #(.WC_W(16)) bus ();

  dphy_tx_packetizer #(.LP_GAP(GAP), .WC_W(16)) dut (
    .TX_BYTE_clk (clk),
    .TX_rst      (rst),
    .bus         (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pay [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                           8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                           8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+2 with the DUT idle; expected bytes come from exp_q
  task automatic run_pkt(input string name, input bit lng, input logic [7:0] di,
                         input logic [15:0] wc, input int ready_delay, input bit stall,
                         input int inject_at, input bit inject_gap);
    int cyc, pi, viol, xfer_cyc, gap_len, idle_bad;
    bit acc, done, hold, saw_rdy;
    logic [7:0] hold_byte;
    logic [31:0] obs;
    got_q.delete();
    pi = 0; viol = 0; xfer_cyc = -10; gap_len = 0; idle_bad = 0;
    acc = 0; done = 0; hold = 0; saw_rdy = 0; hold_byte = 8'h00;
    check_eq({name, ".req_idle"}, 32'(bus.TX_REQ), 32'd0);
    bus.pkt_start = 1'b1; bus.pkt_long = lng; bus.pkt_di = di; bus.pkt_wc = wc;
    @(posedge clk); #2;
    bus.pkt_start = 1'b0; bus.pkt_long = 1'b0; bus.pkt_di = 8'h3F; bus.pkt_wc = 16'h0005;
    for (cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (acc) pi++;
      bus.pkt_start = (cyc == inject_at);
      bus.TX_READY  = stall ? 1'($urandom_range(0, 1)) : (cyc >= ready_delay);
      bus.app_valid = (pi < int'(wc)) && lng && (stall ? ($urandom_range(0, 3) != 0) : 1'b1);
      bus.app_data  = (pi < 24) ? pay[pi] : 8'h00;
      @(negedge clk);
      if (cyc == 0) begin
        check_eq({name, ".req_rise"}, 32'(bus.TX_REQ), 32'd1);
        check_eq({name, ".busy_rise"}, 32'(bus.busy), 32'd1);
      end
      if (bus.app_ready) saw_rdy = 1;
      if (hold && (!bus.TX_VALID || bus.TX_BYTE_HS != hold_byte)) viol++;
      hold      = bus.TX_VALID && !bus.TX_READY;
      hold_byte = bus.TX_BYTE_HS;
      acc       = bus.app_valid && bus.app_ready;
      if (bus.TX_VALID && bus.TX_READY) begin
        got_q.push_back(bus.TX_BYTE_HS);
        xfer_cyc = cyc;
      end
      if (bus.pkt_done) begin
        done = 1;
        check_eq({name, ".end_req"}, 32'(bus.TX_REQ), 32'd0);
        check_eq({name, ".end_valid"}, 32'(bus.TX_VALID), 32'd0);
        check_eq({name, ".done_lat"}, 32'(cyc - xfer_cyc), 32'd1);
      end else begin
        @(posedge clk); #2;
      end
    end
    bus.pkt_start = 1'b0; bus.app_valid = 1'b0;
    check_eq({name, ".done_seen"}, 32'(done), 32'd1);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #2;
      bus.pkt_start = inject_gap && (k == 2);
      @(negedge clk);
      if (k == 0) check_eq({name, ".done_pulse"}, 32'(bus.pkt_done), 32'd0);
      if (!bus.busy) break;
      gap_len++;
    end
    bus.pkt_start = 1'b0;
    check_eq({name, ".gap_len"}, 32'(gap_len), 32'(GAP));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.TX_REQ || bus.busy) idle_bad++;
    end
    check_eq({name, ".stay_idle"}, 32'(idle_bad), 32'd0);
    check_eq({name, ".len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < got_q.size()) ? 32'(got_q[i]) : 32'h100;
      check_eq($sformatf("%s.b%0d", name, i), obs, 32'(exp_q[i]));
    end
    check_eq({name, ".stable"}, 32'(viol), 32'd0);
    check_eq({name, ".app_rdy_seen"}, 32'(saw_rdy), 32'(lng && wc != 16'd0));
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.pkt_start = 1'b0; bus.pkt_long = 1'b0; bus.pkt_di = 8'h00; bus.pkt_wc = 16'h0000;
    bus.app_data = 8'h00; bus.app_valid = 1'b0; bus.TX_READY = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst.req", 32'(bus.TX_REQ), 32'd0);
    check_eq("rst.valid", 32'(bus.TX_VALID), 32'd0);
    check_eq("rst.byte", 32'(bus.TX_BYTE_HS), 32'd0);
    check_eq("rst.app_ready", 32'(bus.app_ready), 32'd0);
    check_eq("rst.busy", 32'(bus.busy), 32'd0);
    check_eq("rst.done", 32'(bus.pkt_done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    exp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_pkt("short0", 1'b0, 8'h00, 16'h0000, 3, 1'b0, -1, 1'b0);

    exp_q = '{8'h01, 8'h00, 8'h00, 8'h07};
    run_pkt("short1", 1'b0, 8'h01, 16'h0000, 0, 1'b0, -1, 1'b0);

    exp_q = '{8'h12, 8'h00, 8'h00, 8'h18, 8'hFF, 8'hFF};
    run_pkt("long0", 1'b1, 8'h12, 16'h0000, 0, 1'b0, -1, 1'b0);

    exp_q = '{8'h12, 8'h18, 8'h00, 8'h1B};
    for (int i = 0; i < 24; i++) exp_q.push_back(pay[i]);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h00);
    run_pkt("long24", 1'b1, 8'h12, 16'd24, 0, 1'b0, 10, 1'b1);
    run_pkt("long24_stall", 1'b1, 8'h12, 16'd24, 0, 1'b1, -1, 1'b0);

    // Abandon a packet mid-payload with an asynchronous reset
    bus.pkt_start = 1'b1; bus.pkt_long = 1'b1; bus.pkt_di = 8'h12; bus.pkt_wc = 16'd24;
    @(posedge clk); #2;
    bus.pkt_start = 1'b0; bus.TX_READY = 1'b1; bus.app_valid = 1'b1; bus.app_data = 8'hA5;
    repeat (8) @(posedge clk);
    #2;
    check_eq("rst_mid.in_pay", 32'(bus.app_ready), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("rst_mid.req", 32'(bus.TX_REQ), 32'd0);
    check_eq("rst_mid.valid", 32'(bus.TX_VALID), 32'd0);
    check_eq("rst_mid.app_ready", 32'(bus.app_ready), 32'd0);
    check_eq("rst_mid.busy", 32'(bus.busy), 32'd0);
    bus.app_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    exp_q = '{8'h01, 8'h00, 8'h00, 8'h07};
    run_pkt("after_rst", 1'b0, 8'h01, 16'h0000, 0, 1'b0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
